pixel_writeback: RTL and testbench

PIXEL_WRITEBACK -- requirements
Module: pixel_writeback

---
 rtl/pixel_wb_pkg.sv | 15 +
 rtl/pixel_wb_expander.sv | 21 ++
 rtl/pixel_writeback.sv | 168 ++++++++++++++++
 tb/tb_pixel_writeback.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_wb_pkg.sv
// Shared types and constants for the pixel write-back block.
package pixel_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StWrite,
    StFinish
  } state_e;

  localparam int unsigned BEAT_BYTES = 32;
  localparam int unsigned BEAT_WORDS = 8;
  localparam int unsigned EXP_WORDS  = 6;

endpackage

// File: rtl/pixel_wb_expander.sv
// 24-bit to 32-bit pixel unpacker: six captured words carry 24 bytes, i.e. eight packed
// RGB pixels taken little-endian; each pixel is widened to {8'h00, rgb24}.
// Only present when PIXEL_WB_EXPAND_EN is defined.
`ifdef PIXEL_WB_EXPAND_EN
module pixel_wb_expander
  import pixel_wb_pkg::*;
(
  input  logic [32*EXP_WORDS-1:0]  pix24_i,
  output logic [32*BEAT_WORDS-1:0] expanded_o
);

  // Pixel j occupies stream bytes 3j..3j+2, which is bit slice [24j +: 24].
  always_comb begin
    expanded_o = '0;
    for (int j = 0; j < BEAT_WORDS; j++) begin
      expanded_o[32*j +: 24] = pix24_i[24*j +: 24];
    end
  end

endmodule
`endif

// File: rtl/pixel_writeback.sv
// Pixel write-back: drains a pixel FIFO into 256-bit Avalon-MM write beats covering one
// frame of total_size bytes starting at base_address.
// Optional feature macro: PIXEL_WB_EXPAND_EN (adds expand_data and the 24->32 unpacker).
module pixel_writeback
  import pixel_wb_pkg::*;
#(
  parameter int unsigned MIN_FILL = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         pix_fifo_read,
  input  logic [31:0]  pix_fifo_data,
  input  logic         pix_fifo_empty,
  input  logic [9:0]   pix_fifo_usedw,
  output logic [32:0]  avl_mm_addr,
  output logic         avl_mm_write,
  output logic [255:0] avl_mm_writedata,
  output logic [31:0]  avl_mm_byteenable,
  input  logic         avl_mm_waitrequest,
  input  logic         enable,
  input  logic         word_mode,
`ifdef PIXEL_WB_EXPAND_EN
  input  logic         expand_data,
`endif
  input  logic [31:0]  base_address,
  input  logic [31:0]  total_size,
  output logic         active,
  output logic         done
);

  state_e       state_q, state_d;
  logic         enable_q;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  remain_q, remain_d;
  logic [255:0] beat_q, beat_d;
  logic [3:0]   pop_cnt_q, pop_cnt_d;
  logic [3:0]   cap_cnt_q, cap_cnt_d;
  logic         cap_vld_q;
  logic         write_q, active_q, done_q;
  logic [3:0]   n_words;
  logic         pop, beat_done, last_cap;

`ifdef PIXEL_WB_EXPAND_EN
  logic         expand_q, expand_d;
  logic [255:0] expanded;

  assign n_words = expand_q ? 4'(EXP_WORDS) : 4'(BEAT_WORDS);

  pixel_wb_expander u_expander (
    .pix24_i    (beat_q[32*EXP_WORDS-1:0]),
    .expanded_o (expanded)
  );

  assign avl_mm_writedata = expand_q ? expanded : beat_q;
`else
  assign n_words          = 4'(BEAT_WORDS);
  assign avl_mm_writedata = beat_q;
`endif

  assign avl_mm_addr       = {1'b0, addr_q};
  assign avl_mm_write      = write_q;
  assign avl_mm_byteenable = '1;
  assign active            = active_q;
  assign done              = done_q;
  assign pix_fifo_read     = pop;

  // Pop strobe: the fill threshold only gates the first pop of a beat, later pops run
  // back-to-back; never pop an empty FIFO.
  always_comb begin
    pop = (state_q == StCollect) && (pop_cnt_q < n_words) &&
          ((pop_cnt_q != 4'd0) || (32'(pix_fifo_usedw) >= MIN_FILL)) && !pix_fifo_empty;
    beat_done = (state_q == StWrite) && !avl_mm_waitrequest;
    last_cap  = cap_vld_q && (cap_cnt_q == n_words - 4'd1);
  end

  // Next-state, address/size bookkeeping and beat capture (data arrives one cycle after pop).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    beat_d    = beat_q;
    pop_cnt_d = pop_cnt_q;
    cap_cnt_d = cap_cnt_q;
`ifdef PIXEL_WB_EXPAND_EN
    expand_d  = expand_q;
`endif
    if (cap_vld_q) begin
      beat_d[{cap_cnt_q[2:0], 5'd0} +: 32] = pix_fifo_data;
      cap_cnt_d = cap_cnt_q + 4'd1;
    end
    if (pop) begin
      pop_cnt_d = pop_cnt_q + 4'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (enable && !enable_q) begin
          addr_d    = base_address;
          remain_d  = total_size;
          pop_cnt_d = 4'd0;
          cap_cnt_d = 4'd0;
`ifdef PIXEL_WB_EXPAND_EN
          expand_d  = expand_data;
`endif
          state_d   = (total_size == 32'd0) ? StFinish : StCollect;
        end
      end
      StCollect: begin
        if (last_cap) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (beat_done) begin
          addr_d    = addr_q + (word_mode ? 32'd1 : 32'(BEAT_BYTES));
          remain_d  = remain_q - 32'(BEAT_BYTES);
          pop_cnt_d = 4'd0;
          cap_cnt_d = 4'd0;
          if (remain_q == 32'(BEAT_BYTES)) begin
            state_d = StFinish;
          end else if (!enable) begin
            state_d = StIdle;
          end else begin
            state_d = StCollect;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      enable_q  <= 1'b0;
      addr_q    <= '0;
      remain_q  <= '0;
      beat_q    <= '0;
      pop_cnt_q <= '0;
      cap_cnt_q <= '0;
      cap_vld_q <= 1'b0;
      write_q   <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef PIXEL_WB_EXPAND_EN
      expand_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      enable_q  <= enable;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      beat_q    <= beat_d;
      pop_cnt_q <= pop_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      cap_vld_q <= pop;
      write_q   <= (state_d == StWrite);
      active_q  <= (state_d != StIdle);
      done_q    <= (state_d == StFinish);
`ifdef PIXEL_WB_EXPAND_EN
      expand_q  <= expand_d;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_writeback.sv
// Scoreboard bench for pixel_writeback: frames are described to a byte-stream reference
// model, expected beats are queued, and a negedge monitor checks every accepted beat.
module tb_pixel_writeback;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_fifo_read;
  logic [31:0]  pix_fifo_data;
  logic         pix_fifo_empty;
  logic [9:0]   pix_fifo_usedw;
  logic [32:0]  avl_mm_addr;
  logic         avl_mm_write;
  logic [255:0] avl_mm_writedata;
  logic [31:0]  avl_mm_byteenable;
  logic         avl_mm_waitrequest;
  logic         enable;
  logic         word_mode;
  logic [31:0]  base_address;
  logic [31:0]  total_size;
  logic         active;
  logic         done;
`ifdef PIXEL_WB_EXPAND_EN
  logic         expand_data;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] fifo_q[$];
  beat_t exp_q[$];
  int cyc_q[$];
  int pop_total = 0;
  int exp_pops = 8;
  int done_seen = 0;
  int done_exp = 0;
  int stall_mode = 0;
  int hold_left = 0;

  always #5 clk = ~clk;

  pixel_writeback #(.MIN_FILL(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .pix_fifo_read      (pix_fifo_read),
    .pix_fifo_data      (pix_fifo_data),
    .pix_fifo_empty     (pix_fifo_empty),
    .pix_fifo_usedw     (pix_fifo_usedw),
    .avl_mm_addr        (avl_mm_addr),
    .avl_mm_write       (avl_mm_write),
    .avl_mm_writedata   (avl_mm_writedata),
    .avl_mm_byteenable  (avl_mm_byteenable),
    .avl_mm_waitrequest (avl_mm_waitrequest),
    .enable             (enable),
    .word_mode          (word_mode),
`ifdef PIXEL_WB_EXPAND_EN
    .expand_data        (expand_data),
`endif
    .base_address       (base_address),
    .total_size         (total_size),
    .active             (active),
    .done               (done)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference beat: 8 raw words, or 24 stream bytes regrouped as eight 3-byte pixels.
  function automatic logic [255:0] model_beat(input logic [31:0] w[$], input int first,
                                              input bit ex);
    logic [255:0] r;
    logic [7:0]   b[24];
    r = '0;
    if (!ex) begin
      for (int k = 0; k < 8; k++) r[32*k +: 32] = w[first + k];
    end else begin
      for (int j = 0; j < 24; j++) b[j] = 8'(w[first + j / 4] >> (8 * (j % 4)));
      for (int p = 0; p < 8; p++) r[32*p +: 32] = {8'h00, b[3*p+2], b[3*p+1], b[3*p]};
    end
    return r;
  endfunction

  // FIFO model: popped word appears on pix_fifo_data the cycle after the pop.
  always @(posedge clk) begin
    if (pix_fifo_read) begin
      pop_total++;
      if (fifo_q.size() != 0) pix_fifo_data <= fifo_q.pop_front();
    end
    pix_fifo_usedw <= 10'(fifo_q.size());
    pix_fifo_empty <= (fifo_q.size() == 0);
  end

  // Slave stall generator.
  always @(posedge clk) begin
    #1;
    if (stall_mode == 2) avl_mm_waitrequest = 1'b1;
    else if (hold_left > 0 && avl_mm_write) begin
      avl_mm_waitrequest = 1'b1;
      hold_left--;
    end else if (stall_mode == 1) avl_mm_waitrequest = ($urandom_range(0, 3) == 0);
    else avl_mm_waitrequest = 1'b0;
  end

  // Monitor: beat scoreboard, stall stability, pop accounting and done width.
  logic         prev_stall = 1'b0;
  logic         prev_done = 1'b0;
  logic [32:0]  prev_addr;
  logic [255:0] prev_data;
  int           wr_cycles = 0;
  int           mon_pops = 0;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
      wr_cycles  = 0;
      mon_pops   = 0;
    end else begin
      if (pix_fifo_read) begin
        check("pop_while_empty", pix_fifo_empty, 1'b0);
        mon_pops++;
      end
      if (prev_stall) begin
        check("stall_write_held", avl_mm_write, 1'b1);
        check("stall_addr_stable", avl_mm_addr, prev_addr);
        check("stall_data_stable", avl_mm_writedata, prev_data);
      end
      if (avl_mm_write) begin
        wr_cycles++;
        check("byteenable", avl_mm_byteenable, 32'hFFFF_FFFF);
        if (!avl_mm_waitrequest) begin
          check("beat_expected", 1'(exp_q.size() != 0), 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("beat_addr", avl_mm_addr, {1'b0, e.addr});
            check("beat_data", avl_mm_writedata, e.data);
          end
          check("pops_per_beat", 32'(mon_pops), 32'(exp_pops));
          cyc_q.push_back(wr_cycles);
          wr_cycles = 0;
          mon_pops  = 0;
        end
      end
      if (done) begin
        done_seen++;
        check("done_width", prev_done, 1'b0);
      end
      prev_stall = avl_mm_write && avl_mm_waitrequest;
      prev_addr  = avl_mm_addr;
      prev_data  = avl_mm_writedata;
    end
    prev_done = done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pat: 0 random words, 1 word index, 2 byte ramp.
  task automatic load_frame(input logic [31:0] base, input logic [31:0] size, input bit wm,
                            input bit ex, input int keep_beats, input int pat);
    logic [31:0] w[$];
    logic [31:0] v;
    int nb;
    int wpb;
    nb  = int'(size / 32);
    wpb = ex ? 6 : 8;
    for (int i = 0; i < nb * wpb; i++) begin
      if (pat == 1) v = 32'(i);
      else if (pat == 2) v = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      else v = $urandom;
      w.push_back(v);
      fifo_q.push_back(v);
    end
    if (ex) for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    for (int b = 0; b < keep_beats; b++)
      exp_q.push_back('{addr: base + 32'(b) * (wm ? 32'd1 : 32'd32),
                        data: model_beat(w, b * wpb, ex)});
    base_address = base;
    total_size   = size;
    word_mode    = wm;
    exp_pops     = wpb;
`ifdef PIXEL_WB_EXPAND_EN
    expand_data  = ex;
`endif
    tick(2);
  endtask

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    tick(2);
    while (active && c < bound) begin
      tick(1);
      c++;
    end
    check("frame_ends_in_time", active, 1'b0);
  endtask

  task automatic run_frame(input bit expect_done);
    enable = 1'b1;
    tick(1);
    wait_idle(400);
    enable = 1'b0;
    tick(2);
    if (expect_done) done_exp++;
    check("done_count", 32'(done_seen), 32'(done_exp));
    fifo_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int c;
    logic [31:0] held;
    rst = 1'b1; enable = 1'b0; word_mode = 1'b0; base_address = '0; total_size = '0;
    avl_mm_waitrequest = 1'b0; pix_fifo_data = '0; pix_fifo_empty = 1'b1;
    pix_fifo_usedw = '0;
`ifdef PIXEL_WB_EXPAND_EN
    expand_data = 1'b0;
`endif
    tick(3);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_write", avl_mm_write, 1'b0);
    check("rst_read", pix_fifo_read, 1'b0);
    check("rst_addr", avl_mm_addr, 33'd0);
    check("rst_data", avl_mm_writedata, 256'd0);
    rst = 1'b0;
    tick(2);

    // Two byte-addressed beats of words 0..15.
    load_frame(32'h1000_0000, 32'd64, 1'b0, 1'b0, 2, 1);
    enable = 1'b1;
    tick(2);
    check("active_in_frame", active, 1'b1);
    wait_idle(400);
    enable = 1'b0;
    tick(2);
    done_exp++;
    check("done_count", 32'(done_seen), 32'(done_exp));
    fifo_q.delete();

    // Word addressing.
    load_frame(32'h0000_0100, 32'd96, 1'b1, 1'b0, 3, 0);
    run_frame(1'b1);

    // Five-cycle stall on the first beat.
    cyc_q.delete();
    hold_left = 5;
    load_frame(32'h0000_2000, 32'd64, 1'b0, 1'b0, 2, 0);
    run_frame(1'b1);
    check("stall_beat_cycles", 32'(cyc_q.size() > 0 ? cyc_q[0] : 0), 32'd6);

    // Fill threshold: seven words must not start a beat.
    load_frame(32'h0000_3000, 32'd32, 1'b0, 1'b0, 1, 0);
    held = fifo_q.pop_back();
    tick(2);
    enable = 1'b1;
    tick(1);
    p0 = pop_total;
    tick(20);
    check("no_pop_below_fill", 32'(pop_total), 32'(p0));
    fifo_q.push_back(held);
    c = 0;
    while (pop_total == p0 && c < 6) begin
      tick(1);
      c++;
    end
    check("pop_start_latency_ok", 1'(c <= 2), 1'b1);
    wait_idle(400);
    enable = 1'b0;
    tick(2);
    done_exp++;
    check("done_count", 32'(done_seen), 32'(done_exp));
    fifo_q.delete();

    // Abort: enable dropped while collecting beat 1 of 4.
    load_frame(32'h0000_4000, 32'd128, 1'b0, 1'b0, 1, 0);
    p0 = pop_total;
    enable = 1'b1;
    c = 0;
    while (pop_total == p0 && c < 20) begin
      tick(1);
      c++;
    end
    enable = 1'b0;
    wait_idle(400);
    tick(30);
    check("abort_done_count", 32'(done_seen), 32'(done_exp));
    check("abort_beats_left", 32'(exp_q.size()), 32'd0);
    fifo_q.delete();

    // Reset while a beat is stalled.
    stall_mode = 2;
    load_frame(32'h0000_5000, 32'd64, 1'b0, 1'b0, 0, 0);
    enable = 1'b1;
    c = 0;
    while (!avl_mm_write && c < 40) begin
      tick(1);
      c++;
    end
    check("write_before_reset", avl_mm_write, 1'b1);
    rst = 1'b1;
    enable = 1'b0;
    tick(1);
    check("reset_write_drop", avl_mm_write, 1'b0);
    check("reset_active_drop", active, 1'b0);
    check("reset_addr", avl_mm_addr, 33'd0);
    rst = 1'b0;
    stall_mode = 0;
    fifo_q.delete();
    tick(3);

    // Empty frame: straight to done.
    load_frame(32'h0000_6000, 32'd0, 1'b0, 1'b0, 0, 0);
    run_frame(1'b1);

    // 32-bit address wrap.
    load_frame(32'hFFFF_FFC0, 32'd96, 1'b0, 1'b0, 3, 0);
    run_frame(1'b1);

`ifdef PIXEL_WB_EXPAND_EN
    load_frame(32'h0000_7000, 32'd64, 1'b0, 1'b1, 2, 2);
    run_frame(1'b1);
`endif

    // Randomised frames with random stalls.
    stall_mode = 1;
    for (int i = 0; i < 8; i++) begin
      bit ex;
      int nb;
      ex = 1'b0;
`ifdef PIXEL_WB_EXPAND_EN
      ex = 1'($urandom_range(0, 1));
`endif
      nb = $urandom_range(1, 6);
      load_frame($urandom, 32'(32 * nb), 1'($urandom_range(0, 1)), ex, nb, 0);
      run_frame(1'b1);
    end
    stall_mode = 0;
    tick(5);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
